// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - multicycle signed 32-bit multiply/divide unit
// Shift-add multiply and restoring divide on magnitudes, one bit per clock.
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic               is_div;
  logic               div_zero;
  logic               div_ovf;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem;

  logic               start;
  logic               start_div;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic [WIDTH:0]     prod_hi;
  logic               mul_exc;

  always_comb begin
    start       = ctrl_MULT | ctrl_DIV;
    start_div   = ctrl_DIV & ~ctrl_MULT;
    abs_a       = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b       = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    // For multiply, prod[WIDTH-1:0] holds the not-yet-consumed multiplier bits.
    mul_sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mag_a : {WIDTH{1'b0}})};
    // For divide, prod[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    div_trial   = {rem, prod[WIDTH-1]} - {2'b00, mag_b};
    prod_signed = neg ? -prod : prod;
    quot_signed = neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    prod_hi     = prod_signed[2*WIDTH-1:WIDTH-1];
    mul_exc     = ~((&prod_hi) | ~(|prod_hi));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      mag_a          <= '0;
      mag_b          <= '0;
      neg            <= 1'b0;
      is_div         <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      prod           <= '0;
      rem            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        state    <= RUN;
        cnt      <= '0;
        mag_a    <= abs_a;
        mag_b    <= abs_b;
        neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        is_div   <= start_div;
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
        prod     <= start_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
        rem      <= '0;
      end else begin
        case (state)
          RUN: begin
            if (is_div) begin
              if (!div_trial[WIDTH+1]) begin
                rem              <= div_trial[WIDTH:0];
                prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b1};
              end else begin
                rem              <= {rem[WIDTH-1:0], prod[WIDTH-1]};
                prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b0};
              end
            end else begin
              prod <= {mul_sum, prod[WIDTH-1:1]};
            end
            if (cnt == CW'(ITER - 1)) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            state          <= IDLE;
            data_resultRDY <= 1'b1;
            if (!is_div) begin
              data_result    <= prod_signed[WIDTH-1:0];
              data_exception <= mul_exc;
            end else if (div_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else begin
              data_result    <= quot_signed;
              data_exception <= div_ovf;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// tb/tb_multdiv_seq.sv - self-checking bench for multdiv_seq
// Directed sign/boundary cases plus random operands against an arithmetic model.
module tb_multdiv_seq;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;

  localparam int LAT = 33;

  multdiv_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    longint hi;
    longint lo;
    int     q;
    hi = 2147483647;
    lo = -hi - 1;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = 32'(p);
      e = (p > hi) || (p < lo);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = 32'h80000000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  // Drives a start so that it is sampled at the next rising edge; returns #1 after that edge.
  task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int seen;
    seen = 0;
    reset_n = 1'b0;
    @(negedge clock);
    data_operandA = 32'd7;
    data_operandB = 32'd6;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    total++;
    if (data_result !== 32'd0 || data_exception !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: result=%h exc=%b, required 0/0", data_result, data_exception);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_no_rdy: rdy pulses=%0d, required 0", seen);
    end
    total++;
    if (data_result !== 32'd0) begin
      bad++;
      $display("FAIL reset_idle_result: result=%h, required 0", data_result);
    end
  endtask

  task automatic test_mult_signs;
    int lat;
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFA);
    wait_rdy(lat);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL mul_latency: edges=%0d, required %0d", lat, LAT);
    end
    total++;
    if (data_result !== 32'hFFFFFFD6 || data_exception !== 1'b0) begin
      bad++;
      $display("FAIL mul_7x-6: result=%h exc=%b, required ffffffd6/0", data_result, data_exception);
    end
    @(posedge clock);
    #1;
    total++;
    if (data_resultRDY !== 1'b0 || data_result !== 32'hFFFFFFD6) begin
      bad++;
      $display("FAIL rdy_one_cycle: rdy=%b result=%h, required 0/ffffffd6", data_resultRDY, data_result);
    end
    start_op(1'b1, 1'b0, 32'hFFFF0000, 32'hFFFF0000);
    wait_rdy(lat);
    total++;
    if (lat !== LAT || data_result !== 32'd0 || data_exception !== 1'b1) begin
      bad++;
      $display("FAIL mul_overflow: lat=%0d result=%h exc=%b, required %0d/0/1", lat, data_result, data_exception, LAT);
    end
  endtask

  task automatic test_divide;
    int lat;
    start_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_rdy(lat);
    total++;
    if (lat !== LAT || data_result !== 32'hFFFFFFFD || data_exception !== 1'b0) begin
      bad++;
      $display("FAIL div_-7/2: lat=%0d result=%h exc=%b, required %0d/fffffffd/0", lat, data_result, data_exception, LAT);
    end
    start_op(1'b0, 1'b1, 32'd100, 32'd0);
    wait_rdy(lat);
    total++;
    if (lat !== LAT || data_result !== 32'd0 || data_exception !== 1'b1) begin
      bad++;
      $display("FAIL div_by_zero: lat=%0d result=%h exc=%b, required %0d/0/1", lat, data_result, data_exception, LAT);
    end
    start_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_rdy(lat);
    total++;
    if (lat !== LAT || data_result !== 32'h80000000 || data_exception !== 1'b1) begin
      bad++;
      $display("FAIL div_min/-1: lat=%0d result=%h exc=%b, required %0d/80000000/1", lat, data_result, data_exception, LAT);
    end
  endtask

  task automatic test_random;
    int          lat;
    bit          is_mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic        ee;
    for (int n = 0; n < 24; n++) begin
      is_mul = n[0];
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = $urandom_range(0, 1000) - 500;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'h80000000;
        3: b = $urandom_range(0, 200) - 100;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(is_mul, a, b, er, ee);
      start_op(is_mul, !is_mul, a, b);
      wait_rdy(lat);
      total++;
      if (lat !== LAT || data_result !== er || data_exception !== ee) begin
        bad++;
        $display("FAIL random_%s a=%h b=%h: lat=%0d result=%h exc=%b, required %0d/%h/%b",
                 is_mul ? "mul" : "div", a, b, lat, data_result, data_exception, LAT, er, ee);
      end
    end
  endtask

  task automatic test_abort;
    logic [31:0] prev;
    int          early;
    int          lat;
    int          held_bad;
    prev     = data_result;
    early    = 0;
    held_bad = 0;
    start_op(1'b1, 1'b0, 32'd3, 32'd5);
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early++;
    end
    start_op(1'b0, 1'b1, 32'd20, 32'd4);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
      if (data_result !== prev) held_bad++;
    end
    total++;
    if (early !== 0 || held_bad !== 0) begin
      bad++;
      $display("FAIL abort_hold: early rdy=%0d changed=%0d, required 0/0", early, held_bad);
    end
    total++;
    if (lat !== LAT || data_result !== 32'd5 || data_exception !== 1'b0) begin
      bad++;
      $display("FAIL abort_restart: lat=%0d result=%h exc=%b, required %0d/5/0", lat, data_result, data_exception, LAT);
    end
  endtask

  task automatic test_simultaneous;
    int lat;
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    wait_rdy(lat);
    total++;
    if (lat !== LAT || data_result !== 32'd18 || data_exception !== 1'b0) begin
      bad++;
      $display("FAIL both_start: lat=%0d result=%h exc=%b, required %0d/12/0", lat, data_result, data_exception, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_rdy(lat);
    start_op(1'b0, 1'b1, 32'd1000, 32'hFFFFFFF6);
    wait_rdy(lat);
    total++;
    if (lat !== LAT || data_result !== 32'hFFFFFF9C || data_exception !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back: lat=%0d result=%h exc=%b, required %0d/ffffff9c/0", lat, data_result, data_exception, LAT);
    end
  endtask

  task automatic test_mid_reset;
    int seen;
    int lat;
    seen = 0;
    start_op(1'b1, 1'b0, 32'h00010000, 32'h00010000);
    wait_rdy(lat);
    start_op(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_clear: result=%h exc=%b rdy=%b, required 0/0/0", data_result, data_exception, data_resultRDY);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    total++;
    if (seen !== 0 || data_result !== 32'd0) begin
      bad++;
      $display("FAIL reset_abort: rdy pulses=%0d result=%h, required 0/0", seen, data_result);
    end
    start_op(1'b1, 1'b0, 32'hFFFFFFF4, 32'd11);
    wait_rdy(lat);
    total++;
    if (lat !== LAT || data_result !== 32'hFFFFFF7C || data_exception !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_op: lat=%0d result=%h exc=%b, required %0d/ffffff7c/0", lat, data_result, data_exception, LAT);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    test_reset();
    test_mult_signs();
    test_divide();
    test_random();
    test_abort();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
